mem_bus_initiator: RTL and testbench

- Initiator end of the picorv32 native memory interface, counterpart to the core-side memory model.
- Pops read/write commands from a small command FIFO and drives look-ahead signals one cycle before each transfer, then the valid/ready transfer itself.
- Returns read data or status on a response port.
- Used by the fuzzing bench to exercise the memory model without the CPU core, and to replay captured bus traffic.

---
 rtl/mem_bus_initiator.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_initiator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_initiator.sv
// Initiator side of the picorv32 native memory bus: queues commands, drives a
// look-ahead cycle, then the valid/ready transfer, and returns a response.
module mem_bus_initiator #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    input  logic        cmd_instr,
    output logic        mem_la_read,
    output logic        mem_la_write,
    output logic [31:0] mem_la_addr,
    output logic [31:0] mem_la_wdata,
    output logic [3:0]  mem_la_wstrb,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, LA, WAIT, RESP} state_t;

    cmd_t          fifo_q [CMD_DEPTH];
    cmd_t          hold_q;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q;
    logic          wait_done, wait_err;
    logic [31:0]   bus_addr;
    logic          is_read;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign bus_addr  = hold_q.addr & 32'hFFFF_FFFC;
    assign is_read   = (hold_q.wstrb == 4'b0000);

    // Storage is not reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr[AW-1:0]] <= '{cmd_addr, cmd_wdata, cmd_wstrb, cmd_instr};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= fifo_q[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        wait_done    = 1'b0;
        wait_err     = 1'b0;
        mem_la_read  = 1'b0;
        mem_la_write = 1'b0;
        mem_la_addr  = '0;
        mem_la_wdata = '0;
        mem_la_wstrb = '0;
        mem_valid    = 1'b0;
        mem_instr    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        rsp_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LA;
                end
            end
            LA: begin
                mem_la_read  = is_read;
                mem_la_write = !is_read;
                mem_la_addr  = bus_addr;
                mem_la_wdata = hold_q.wdata;
                mem_la_wstrb = hold_q.wstrb;
                state_d      = WAIT;
            end
            WAIT: begin
                mem_valid = 1'b1;
                mem_instr = hold_q.instr && is_read;
                mem_addr  = bus_addr;
                mem_wdata = hold_q.wdata;
                mem_wstrb = hold_q.wstrb;
                // A ready on the threshold cycle wins over the timeout.
                if (mem_ready) begin
                    wait_done = 1'b1;
                    state_d   = RESP;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    wait_done = 1'b1;
                    wait_err  = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wcnt_q    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            wcnt_q <= (state_q == WAIT) ? wcnt_q + 1'b1 : '0;
            if (wait_done) begin
                rsp_rdata <= (!wait_err && is_read) ? mem_rdata : 32'h0;
                rsp_err   <= wait_err;
                txn_count <= txn_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator: a vector table of single transfers plus
// hand sequences for backpressure, timeout-then-queue and reset mid-transfer.
module tb_mem_bus_initiator;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        cmd_instr;
    logic        mem_la_read, mem_la_write;
    logic [31:0] mem_la_addr, mem_la_wdata;
    logic [3:0]  mem_la_wstrb;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] txn_count;

    localparam logic [31:0] K = 32'hA5A5_0000;
    logic        auto_rd;
    logic [31:0] rdata_drv;
    assign mem_rdata = auto_rd ? (mem_addr ^ K) : rdata_drv;

    always #5 clk = ~clk;

    mem_bus_initiator #(.CMD_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_instr(cmd_instr),
        .mem_la_read(mem_la_read), .mem_la_write(mem_la_write), .mem_la_addr(mem_la_addr),
        .mem_la_wdata(mem_la_wdata), .mem_la_wstrb(mem_la_wstrb),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .txn_count(txn_count)
    );

    int n_chk = 0;
    int n_pass = 0;
    int exp_txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          rdy_at;   // WAIT cycle (1-based) carrying mem_ready; 0 = never
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic        e_instr;
        logic        e_lar;
        logic        e_law;
        int          e_vcyc;
        logic [31:0] e_rsp;
        logic        e_err;
    } vec_t;

    vec_t tv [6];

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic ins);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_instr = ins;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int vcyc;
        int bad;
        string tag;
        tag = $sformatf("v%0d", idx);
        push_cmd(v.addr, v.wdata, v.wstrb, v.instr);
        for (int c = 0; c < 8 && !(mem_la_read || mem_la_write); c++) @(negedge clk);
        chk({tag, "_la_read"},  mem_la_read,  v.e_lar);
        chk({tag, "_la_write"}, mem_la_write, v.e_law);
        chk({tag, "_la_addr"},  mem_la_addr,  v.e_addr);
        chk({tag, "_la_wdata"}, mem_la_wdata, v.wdata);
        chk({tag, "_la_wstrb"}, mem_la_wstrb, v.wstrb);
        chk({tag, "_la_nvalid"}, mem_valid,   1'b0);
        @(negedge clk);
        vcyc = 0;
        bad  = 0;
        while (mem_valid && vcyc < 40) begin
            vcyc++;
            if (mem_addr !== v.e_addr || mem_wdata !== v.wdata || mem_wstrb !== v.wstrb ||
                mem_instr !== v.e_instr || mem_la_read || mem_la_write) bad++;
            if (vcyc == v.rdy_at) begin
                mem_ready = 1'b1;
                rdata_drv = v.rdata;
            end
            @(negedge clk);
            mem_ready = 1'b0;
        end
        exp_txn++;
        chk({tag, "_wait_bus"},  bad, 0);
        chk({tag, "_vcycles"},   vcyc, v.e_vcyc);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.e_rsp);
        chk({tag, "_rsp_err"},   rsp_err, v.e_err);
        chk({tag, "_txn"},       txn_count, exp_txn);
        @(negedge clk);
        chk({tag, "_rsp_clr"},   rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt, got, last, bad;
        logic sent5;

        tv[0] = '{32'h0000_0010, 32'h0, 4'h0, 1'b1, 1, 32'h0010_0093, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 1, 32'h0010_0093, 1'b0};
        tv[1] = '{32'h0001_0003, 32'hAABB_CCDD, 4'b1000, 1'b1, 1, 32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 1'b0, 1'b1, 1, 32'h0, 1'b0};
        tv[2] = '{32'h2000_0006, 32'h5555_AAAA, 4'h0, 1'b0, 3, 32'h1234_5678, 32'h2000_0004, 1'b0, 1'b1, 1'b0, 3, 32'h1234_5678, 1'b0};
        tv[3] = '{32'h0000_0040, 32'h0, 4'h0, 1'b1, 0, 32'hFFFF_FFFF, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 16, 32'h0, 1'b1};
        tv[4] = '{32'h0000_0100, 32'h0102_0304, 4'hF, 1'b0, 2, 32'h0000_0077, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 2, 32'h0, 1'b0};
        tv[5] = '{32'h0000_0080, 32'h0, 4'h0, 1'b0, 16, 32'hCAFE_F00D, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 16, 32'hCAFE_F00D, 1'b0};

        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        cmd_instr = 1'b0; mem_ready = 1'b0; rsp_ready = 1'b1; auto_rd = 1'b0; rdata_drv = '0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_la", {mem_la_read, mem_la_write}, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);
        chk("rst_txn", txn_count, 16'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(tv[i], i);

        // Timeout with a second command queued behind it.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_wstrb = 4'h0; cmd_instr = 1'b0;
        @(negedge clk);
        cmd_addr = 32'h204;
        @(negedge clk);
        cmd_valid = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 60 && !rsp_valid; c++) begin
            if (mem_valid) vcnt++;
            @(negedge clk);
        end
        exp_txn++;
        chk("to_vcycles", vcnt, 16);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 32'h0);
        auto_rd = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
        exp_txn++;
        chk("to_next_valid", rsp_valid, 1'b1);
        chk("to_next_err", rsp_err, 1'b0);
        chk("to_next_rdata", rsp_rdata, 32'h204 ^ K);
        chk("to_next_txn", txn_count, exp_txn);
        @(negedge clk);

        // Backpressure: response stalled while the FIFO fills.
        rsp_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!cmd_ready) bad++;
            cmd_valid = 1'b1; cmd_addr = 32'h1000 + 32'(i * 4); cmd_wstrb = 4'h0;
        end
        chk("bp_accept5", bad, 0);
        @(negedge clk);
        cmd_addr = 32'h1014;
        chk("bp_full", cmd_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("bp_still_full", cmd_ready, 1'b0);
        chk("bp_rsp0_valid", rsp_valid, 1'b1);
        chk("bp_rsp0_rdata", rsp_rdata, 32'h1000 ^ K);
        rsp_ready = 1'b1;
        got = 1; last = -1; sent5 = 1'b0; bad = 0;
        for (int c = 0; c < 80 && got < 6; c++) begin
            @(negedge clk);
            if (sent5) cmd_valid = 1'b0;
            if (rsp_valid) begin
                if (rsp_rdata !== ((32'h1000 + 32'(got * 4)) ^ K) || rsp_err) bad++;
                if (c - last != 3) bad++;
                last = c;
                got++;
            end
            if (cmd_valid && cmd_ready) sent5 = 1'b1;
        end
        cmd_valid = 1'b0;
        exp_txn += 6;
        chk("bp_order_spacing", bad, 0);
        chk("bp_count", got, 6);
        @(negedge clk);
        chk("bp_txn", txn_count, exp_txn);

        // Reset in the middle of a transfer, with more commands queued.
        auto_rd = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_wstrb = 4'h0;
        @(negedge clk);
        cmd_addr = 32'h304;
        @(negedge clk);
        cmd_addr = 32'h308;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 10 && !mem_valid; c++) @(negedge clk);
        chk("rw_in_wait", mem_valid, 1'b1);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("rw_mem_valid", mem_valid, 1'b0);
        chk("rw_cmd_ready", cmd_ready, 1'b1);
        chk("rw_txn", txn_count, 16'd0);
        chk("rw_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (24) begin
            @(negedge clk);
            if (rsp_valid || mem_valid || mem_la_read || mem_la_write) bad++;
        end
        chk("rw_quiet_after", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
